// File: rtl/execute_ctrl_pkg.sv
// Shared definitions for the Execute-stage control block: opcodes, condition
// codes, halt sequencing states and the flag-class decode.
package execute_ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] CC_NE   = 3'b000;
  localparam logic [2:0] CC_EQ   = 3'b001;
  localparam logic [2:0] CC_GT   = 3'b010;
  localparam logic [2:0] CC_LT   = 3'b011;
  localparam logic [2:0] CC_GTE  = 3'b100;
  localparam logic [2:0] CC_LTE  = 3'b101;
  localparam logic [2:0] CC_OVFL = 3'b110;
  localparam logic [2:0] CC_UNC  = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_e;

  // Flag mask bit order is {Z, N, V} everywhere in this block.
  function automatic logic [2:0] writes_flags(input logic [3:0] opcode);
    logic [2:0] mask;
    mask = 3'b000;
    case (opcode)
      OP_ADD, OP_SUB:                 mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask = 3'b100;
      default:                        mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/execute_ctrl_branch_cond_eval.sv
// Branch condition evaluator: resolves a ccc field against the flags and
// reports which flags the condition depends on ({Z, N, V}).
module branch_cond_eval
  import execute_ctrl_pkg::*;
(
  input  logic       i_cond_valid,
  input  logic [2:0] i_cond,
  input  logic       i_flag_z,
  input  logic       i_flag_n,
  input  logic       i_flag_v,
  output logic       o_cond_true,
  output logic [2:0] o_needs_flags
);

  always_comb begin
    o_cond_true   = 1'b0;
    o_needs_flags = 3'b000;
    case (i_cond)
      CC_NE:   begin o_cond_true = ~i_flag_z;              o_needs_flags = 3'b100; end
      CC_EQ:   begin o_cond_true = i_flag_z;               o_needs_flags = 3'b100; end
      CC_GT:   begin o_cond_true = ~i_flag_z & ~i_flag_n;  o_needs_flags = 3'b110; end
      CC_LT:   begin o_cond_true = i_flag_n;               o_needs_flags = 3'b010; end
      CC_GTE:  begin o_cond_true = i_flag_z | ~i_flag_n;   o_needs_flags = 3'b110; end
      CC_LTE:  begin o_cond_true = i_flag_z | i_flag_n;    o_needs_flags = 3'b110; end
      CC_OVFL: begin o_cond_true = i_flag_v;               o_needs_flags = 3'b001; end
      default: begin o_cond_true = 1'b1;                   o_needs_flags = 3'b000; end
    endcase
    // Gating here keeps a non-branch ID slot from ever looking like a consumer.
    if (!i_cond_valid) begin
      o_cond_true   = 1'b0;
      o_needs_flags = 3'b000;
    end
  end

endmodule

// File: rtl/execute_ctrl.sv
// Execute-stage sequencer: ID/EX control register, flag write enables,
// branch flag-hazard stall, branch resolution and HLT drain/halt.
module execute_ctrl
  import execute_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [3:0] id_opcode,
  input  logic [2:0] id_cond,
  input  logic       mem_stall,
  input  logic       flag_z,
  input  logic       flag_n,
  input  logic       flag_v,
  output logic       ex_valid,
  output logic [3:0] ex_opcode,
  output logic       en_Z,
  output logic       en_N,
  output logic       en_V,
  output logic       id_stall,
  output logic       branch_taken,
  output logic       halted
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  logic        r_ex_valid;
  logic [3:0]  r_ex_opcode;
  halt_state_e r_state;
  logic [3:0]  r_cnt;

  logic        w_id_branch;
  logic        w_cond_true;
  logic [2:0]  w_needs_flags;
  logic [2:0]  w_ex_writes;
  logic        w_hazard;
  logic        w_id_stall;
  logic        w_capture;

  assign w_id_branch = id_valid & ((id_opcode == OP_B) | (id_opcode == OP_BR));

  branch_cond_eval u_branch_cond_eval (
    .i_cond_valid  (w_id_branch),
    .i_cond        (id_cond),
    .i_flag_z      (flag_z),
    .i_flag_n      (flag_n),
    .i_flag_v      (flag_v),
    .o_cond_true   (w_cond_true),
    .o_needs_flags (w_needs_flags)
  );

  assign w_ex_writes = writes_flags(r_ex_opcode);
  assign w_hazard    = w_id_branch & r_ex_valid & (|(w_needs_flags & w_ex_writes));
  assign w_id_stall  = w_hazard | mem_stall | (r_state != ST_RUN);
  assign w_capture   = id_valid & ~w_id_stall;

  // Enables fire only on the cycle EX actually advances, so each flag is written once.
  assign en_Z = r_ex_valid & w_ex_writes[2] & ~mem_stall;
  assign en_N = r_ex_valid & w_ex_writes[1] & ~mem_stall;
  assign en_V = r_ex_valid & w_ex_writes[0] & ~mem_stall;

  assign id_stall     = w_id_stall;
  assign branch_taken = w_id_branch & ~w_id_stall & w_cond_true;
  assign ex_valid     = r_ex_valid;
  assign ex_opcode    = r_ex_opcode;
  assign halted       = (r_state == ST_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_opcode <= 4'h0;
    end else if (!mem_stall) begin
      if (w_capture) begin
        r_ex_valid  <= 1'b1;
        r_ex_opcode <= id_opcode;
      end else begin
        r_ex_valid  <= 1'b0;
        r_ex_opcode <= 4'h0;
      end
    end
  end

  // Drain counts non-stalled edges after HLT lands in EX; HALTED holds until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= 4'h0;
    end else if (!mem_stall) begin
      case (r_state)
        ST_RUN: begin
          if (w_capture && (id_opcode == OP_HLT)) begin
            r_state <= ST_DRAIN;
            r_cnt   <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          r_cnt <= r_cnt - 4'h1;
          if (r_cnt <= 4'h1) begin
            r_state <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= 4'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_ctrl.sv
// Self-checking bench for execute_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_execute_ctrl;

  localparam int DRAIN = 3;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic [2:0] id_cond;
  logic       mem_stall;
  logic       flag_z;
  logic       flag_n;
  logic       flag_v;
  logic       ex_valid;
  logic [3:0] ex_opcode;
  logic       en_Z;
  logic       en_N;
  logic       en_V;
  logic       id_stall;
  logic       branch_taken;
  logic       halted;

  int checks = 0;
  int errors = 0;

  // Model: contents of EX, remaining drain edges (0 = not draining), halted flag
  bit       mExValid;
  bit [3:0] mExOp;
  int       mDrainLeft;
  bit       mHalted;

  execute_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_cond      (id_cond),
    .mem_stall    (mem_stall),
    .flag_z       (flag_z),
    .flag_n       (flag_n),
    .flag_v       (flag_v),
    .ex_valid     (ex_valid),
    .ex_opcode    (ex_opcode),
    .en_Z         (en_Z),
    .en_N         (en_N),
    .en_V         (en_V),
    .id_stall     (id_stall),
    .branch_taken (branch_taken),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compareVal(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit [2:0] mWrites(input bit [3:0] op);
    if (op == 4'h0 || op == 4'h1) return 3'b111;
    if (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6) return 3'b100;
    return 3'b000;
  endfunction

  function automatic bit [2:0] mNeeds(input bit [2:0] cc);
    bit [2:0] table8 [8];
    table8 = '{3'b100, 3'b100, 3'b110, 3'b010, 3'b110, 3'b110, 3'b001, 3'b000};
    return table8[cc];
  endfunction

  function automatic bit mCondTrue(input bit [2:0] cc, input bit z, input bit n, input bit v);
    bit [7:0] truth;
    truth = {1'b1, v, z | n, z | !n, n, !z && !n, z, !z};
    return truth[cc];
  endfunction

  function automatic bit mIsBranch();
    return id_valid && (id_opcode == 4'hC || id_opcode == 4'hD);
  endfunction

  function automatic bit mStall();
    bit hz;
    hz = mIsBranch() && mExValid && ((mNeeds(id_cond) & mWrites(mExOp)) != 3'b000);
    return hz || mem_stall || (mDrainLeft > 0) || mHalted;
  endfunction

  task automatic checkOutput();
    bit [2:0] en;
    bit       tk;
    en = (mExValid && !mem_stall) ? mWrites(mExOp) : 3'b000;
    tk = mIsBranch() && !mStall() && mCondTrue(id_cond, flag_z, flag_n, flag_v);
    compareVal("ex_valid", ex_valid, mExValid);
    compareVal("ex_opcode", ex_opcode, mExOp);
    compareVal("en_Z", en_Z, en[2]);
    compareVal("en_N", en_N, en[1]);
    compareVal("en_V", en_V, en[0]);
    compareVal("id_stall", id_stall, mStall());
    compareVal("branch_taken", branch_taken, tk);
    compareVal("halted", halted, mHalted);
  endtask

  task automatic stepModel();
    bit st;
    st = mStall();
    if (!mem_stall) begin
      if (mDrainLeft > 0) begin
        if (mDrainLeft == 1) mHalted = 1'b1;
        mDrainLeft--;
      end
      if (!st && id_valid) begin
        mExValid = 1'b1;
        mExOp    = id_opcode;
        if (id_opcode == 4'hF) mDrainLeft = DRAIN;
      end else begin
        mExValid = 1'b0;
        mExOp    = 4'h0;
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input bit [3:0] op, input bit [2:0] cc,
                               input bit ms, input bit fz, input bit fn, input bit fv);
    id_valid  = v;
    id_opcode = op;
    id_cond   = cc;
    mem_stall = ms;
    flag_z    = fz;
    flag_n    = fn;
    flag_v    = fv;
  endtask

  task automatic runCycle(input bit v, input bit [3:0] op, input bit [2:0] cc,
                          input bit ms, input bit fz, input bit fn, input bit fv);
    applyStimulus(v, op, cc, ms, fz, fn, fv);
    #3;
    checkOutput();
  endtask

  task automatic nextEdge();
    stepModel();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    mExValid   = 1'b0;
    mExOp      = 4'h0;
    mDrainLeft = 0;
    mHalted    = 1'b0;
  endtask

  // Asynchronous reset: outputs are checked before any clock edge arrives.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    compareVal("rst_ex_valid", ex_valid, 1'b0);
    compareVal("rst_halted", halted, 1'b0);
    if (!mem_stall) compareVal("rst_id_stall", id_stall, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic randomCycle();
    bit       v;
    int       r;
    bit [3:0] op;
    v = ($urandom % 10) < 8;
    r = $urandom % 100;
    if (r < 3)       op = 4'hF;
    else if (r < 22) op = 4'hC;
    else if (r < 40) op = 4'hD;
    else begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF) op = 4'h0;
    end
    runCycle(v, op, 3'($urandom_range(0, 7)), ($urandom % 5) == 0,
             1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic haltLatency(input string name, input int stallAt, input int expected);
    int edges;
    runCycle(1, 4'hF, 3'd7, 0, 0, 0, 0);
    nextEdge();
    compareVal({name, "_ex_opcode"}, ex_opcode, 8'h0F);
    for (edges = 0; edges < 20; edges++) begin
      runCycle(1, 4'h0, 3'd7, edges == stallAt, 0, 0, 0);
      if (halted === 1'b1) break;
      if (edges == 0) compareVal({name, "_stall"}, id_stall, 1'b1);
      nextEdge();
    end
    compareVal({name, "_latency"}, 8'(edges), 8'(expected));
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 4'h0, 3'd0, 0, 0, 0, 0);
    modelReset();
    #2;
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ADD in EX, B EQ in ID: one hazard stall, then resolve with new Z
    runCycle(1, 4'h0, 3'd0, 0, 0, 0, 0);
    nextEdge();
    runCycle(1, 4'hC, 3'b001, 0, 0, 0, 0);
    compareVal("t1_stall", id_stall, 1'b1);
    compareVal("t1_taken", branch_taken, 1'b0);
    nextEdge();
    runCycle(1, 4'hC, 3'b001, 0, 1, 0, 0);
    compareVal("t1_bubble", ex_valid, 1'b0);
    compareVal("t1_stall2", id_stall, 1'b0);
    compareVal("t1_taken2", branch_taken, 1'b1);
    nextEdge();

    // XOR in EX does not write N, so LT resolves immediately
    runCycle(1, 4'h2, 3'd0, 0, 0, 0, 0);
    nextEdge();
    runCycle(1, 4'hC, 3'b011, 0, 0, 1, 0);
    compareVal("t2_stall", id_stall, 1'b0);
    compareVal("t2_taken", branch_taken, 1'b1);
    compareVal("t2_enZ", en_Z, 1'b1);
    compareVal("t2_enN", en_N, 1'b0);
    compareVal("t2_enV", en_V, 1'b0);
    nextEdge();

    // Unconditional BR behind SUB
    runCycle(1, 4'h1, 3'd0, 0, 0, 0, 0);
    nextEdge();
    runCycle(1, 4'hD, 3'b111, 0, 0, 0, 0);
    compareVal("t3_stall", id_stall, 1'b0);
    compareVal("t3_taken", branch_taken, 1'b1);
    nextEdge();

    // ADD held under two stall cycles, enables only on release
    runCycle(1, 4'h0, 3'd0, 0, 0, 0, 0);
    nextEdge();
    for (int i = 0; i < 2; i++) begin
      runCycle(0, 4'h0, 3'd0, 1, 0, 0, 0);
      compareVal("t4_hold_valid", ex_valid, 1'b1);
      compareVal("t4_hold_op", ex_opcode, 8'h00);
      compareVal("t4_hold_en", {en_Z, en_N, en_V}, 8'h0);
      nextEdge();
    end
    runCycle(0, 4'h0, 3'd0, 0, 0, 0, 0);
    compareVal("t4_release_en", {en_Z, en_N, en_V}, 8'h7);
    nextEdge();
    runCycle(0, 4'h0, 3'd0, 0, 0, 0, 0);
    compareVal("t4_after_en", {en_Z, en_N, en_V}, 8'h0);
    nextEdge();

    // Halt drain, plain and with one stalled edge
    haltLatency("t5a", -1, DRAIN);
    doReset();
    haltLatency("t5b", 1, DRAIN + 1);
    for (int i = 0; i < 10; i++) begin
      nextEdge();
      runCycle(1, 4'hC, 3'd7, 0, 0, 0, 0);
      compareVal("t5_sticky", halted, 1'b1);
      compareVal("t5_no_taken", branch_taken, 1'b0);
    end

    // Reset in the middle of DRAIN, then normal flow
    doReset();
    runCycle(1, 4'hF, 3'd0, 0, 0, 0, 0);
    nextEdge();
    runCycle(1, 4'h0, 3'd0, 0, 0, 0, 0);
    nextEdge();
    runCycle(0, 4'h0, 3'd0, 0, 0, 0, 0);
    doReset();
    runCycle(1, 4'h0, 3'd0, 0, 0, 0, 0);
    nextEdge();
    runCycle(0, 4'h0, 3'd0, 0, 0, 0, 0);
    compareVal("t6_ex_valid", ex_valid, 1'b1);
    compareVal("t6_enZ", en_Z, 1'b1);
    nextEdge();

    // Randomized traffic, each episode ends in a mid-cycle reset
    for (int ep = 0; ep < 6; ep++) begin
      int len;
      len = $urandom_range(150, 300);
      for (int i = 0; i < len; i++) begin
        randomCycle();
        if (i == len - 1) doReset();
        else nextEdge();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
